mod_lif_neuron: RTL and testbench
=================================

Name: mod_lif_neuron

Overview:
- Leaky integrate-and-fire neuron stage. Directly upstream of the spider's D-latch stage: drives that latch's data input and its `crit` enable.
- Accumulates signed synaptic weights into a membrane potential and leaks it periodically.
- On reaching threshold, emits a spike. `critOut` is framed so the downstream latch captures the spike cleanly, then the neuron enters refractory.

Parameters:
- IN_W, 8, width of signed synaptic weight input
- ACC_W, 12, width of signed membrane potential accumulator
- THRESH, 1000, firing threshold (positive, < 2^(ACC_W-1))
- LEAK_PERIOD, 8, clock cycles between leak events (>=1)
- LEAK_SHIFT, 4, leak amount = potential >>> LEAK_SHIFT
- FIRE_CYCLES, 2, cycles `critOut` is held high per spike (>=1)
- REFRACT, 16, refractory length in cycles (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rstN  in  1  asynchronous active-low reset
- inValid  in  1  weight present this cycle
- inWeight  in  IN_W  signed synaptic weight, sampled when inValid=1
- spikeOut  out  1  spike level; feeds latch data input
- critOut  out  1  latch enable window; feeds latch crit
- potential  out  ACC_W  current signed membrane potential (registered)
- refractory  out  1  high while in REFRACT state

Behaviour:
- Reset (rstN=0, async): state=INTEGRATE; potential=0; spikeOut=0; critOut=0; refractory=0; leak and state counters=0.
  - Reset asserted mid-spike or mid-refractory aborts immediately.
  - First edge after release behaves as INTEGRATE.
- All outputs are registered.
- Leak counter: free-running modulo LEAK_PERIOD in all states. leakTick=1 when the counter equals LEAK_PERIOD-1.
- INTEGRATE, per cycle:
  - p1 = leakTick ? potential - (potential >>> LEAK_SHIFT) : potential.
  - p2 = inValid ? p1 + signext(inWeight) : p1.
  - Arithmetic is done at ACC_W+1 bits, then saturated to [0, 2^(ACC_W-1)-1]. Potential never goes negative; it floors at 0.
  - If p2 >= THRESH: potential <= p2, next state FIRE, counter=0.
  - Otherwise potential <= p2.
  - Leak and input in the same cycle: leak first, then add.
- FIRE:
  - spikeOut=1 for FIRE_CYCLES+1 cycles.
  - critOut=1 for the first FIRE_CYCLES of those cycles.
  - critOut therefore falls one cycle before spikeOut, so the latch closes with data stable at 1.
  - The first FIRE cycle asserts both outputs on the edge following the threshold crossing, so latency from the crossing input is 1 cycle.
  - Inputs are ignored in FIRE; potential holds.
  - After FIRE_CYCLES+1 cycles: potential <= 0, next state REFRACT, refractory=1, counter=0.
- REFRACT:
  - spikeOut=0, critOut=0, potential held at 0.
  - inValid is ignored, and weights are discarded (not buffered).
  - After REFRACT cycles: refractory=0, next state INTEGRATE.
- critOut is never high while spikeOut=0.
- A threshold exactly equal to THRESH fires.
- Back-to-back spikes are separated by at least FIRE_CYCLES+1+REFRACT cycles.

Optional Feature:
- Macro LIF_LEAK_EN.
- Defined: the leak operates as described above.
- Undefined:
  - No leak counter is instantiated and leakTick is constant 0.
  - The neuron is a pure integrator; potential changes only on inValid.
- All other timing is identical in both builds.

Test Plan:
- Reset mid-operation: assert rstN=0 during FIRE cycle 1 -> spikeOut, critOut and potential all read 0 immediately (asynchronous); after release, state is INTEGRATE.
- Pure integration (LIF_LEAK_EN undefined):
  - Stimulus: 10 consecutive inValid pulses, inWeight=100.
  - After the 10th pulse, potential=1000.
  - Next edge: spikeOut=1 and critOut=1.
  - critOut stays high 2 cycles; spikeOut stays high 3 cycles.
  - potential then reads 0 and refractory=1 for 16 cycles.
- Leak (LIF_LEAK_EN defined):
  - Stimulus: load potential to 800, then no input for 8 cycles.
  - After the leak tick, potential=750.
  - After a further 8 cycles, potential=704 (750-46).
- Negative floor and saturation:
  - potential=50, inWeight=-128 -> potential=0.
  - With THRESH set to 2047 and repeated inWeight=127 -> potential saturates at 2047, then fires.
- Refractory discard: during REFRACT, apply inValid with inWeight=127 for all 16 cycles -> potential stays 0 and no spike occurs; the first accepted input afterwards yields potential=127.
- Latch framing:
  - Checker over the whole run: critOut is high only when spikeOut is high.
  - Each critOut falling edge occurs with spikeOut=1.
  - A connected latch model holds 1 after every spike.

Source files
------------

// File: rtl/mod_lif_neuron_if.sv
`default_nettype none
// ============================================================================
//  Module   : mod_lif_neuron_if
//  Purpose  : Bundles the synaptic input and the spike/latch-framing outputs
//             of the leaky integrate-and-fire neuron.
//  Signals  : inValid    - weight present this cycle (to neuron)
//             inWeight   - signed synaptic weight, IN_W bits (to neuron)
//             spikeOut   - spike level, drives downstream latch data
//             critOut    - latch enable window, drives downstream latch crit
//             potential  - registered signed membrane potential, ACC_W bits
//             refractory - high while the neuron is refractory
//  Modports : master (weight source / latch side), slave (neuron)
//  Revision : 1.0 - initial release
// ============================================================================
interface mod_lif_neuron_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 12
);
    logic                    inValid;
    logic signed [IN_W-1:0]  inWeight;
    logic                    spikeOut;
    logic                    critOut;
    logic signed [ACC_W-1:0] potential;
    logic                    refractory;

    modport master (
        output inValid, inWeight,
        input  spikeOut, critOut, potential, refractory
    );

    modport slave (
        input  inValid, inWeight,
        output spikeOut, critOut, potential, refractory
    );
endinterface
`default_nettype wire

// File: rtl/mod_lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module   : mod_lif_neuron
//  Purpose  : Leaky integrate-and-fire neuron feeding a downstream D-latch.
//             Integrates signed weights into a saturating, non-negative
//             membrane potential; on reaching THRESH it raises spikeOut for
//             FIRE_CYCLES+1 cycles with critOut high for the first
//             FIRE_CYCLES of them, then goes refractory for REFRACT cycles.
//  Ports    : clk  - system clock, rising edge
//             rstN - asynchronous active-low reset
//             nrn  - mod_lif_neuron_if.slave (inValid, inWeight, spikeOut,
//                    critOut, potential, refractory)
//  Options  : LIF_LEAK_EN - when defined, a free-running leak counter
//             subtracts potential>>>LEAK_SHIFT every LEAK_PERIOD cycles;
//             when undefined the neuron is a pure integrator.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_lif_neuron #(
    parameter int IN_W        = 8,
    parameter int ACC_W       = 12,
    parameter int THRESH      = 1000,
    parameter int LEAK_PERIOD = 8,
    parameter int LEAK_SHIFT  = 4,
    parameter int FIRE_CYCLES = 2,
    parameter int REFRACT     = 16
) (
    input  wire logic           clk,
    input  wire logic           rstN,
    mod_lif_neuron_if.slave     nrn
);

    // One shared counter serves both the FIRE and REFRACT phases.
    localparam int c_CNT_MAX = (FIRE_CYCLES + 1 > REFRACT - 1) ? FIRE_CYCLES + 1 : REFRACT - 1;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [ACC_W-1:0]   c_P_MAX     = ACC_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic [ACC_W-1:0]   c_THRESH    = ACC_W'(THRESH);
    localparam logic [c_CNT_W-1:0] c_FIRE_LAST = c_CNT_W'(FIRE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_FIRE_CRIT = c_CNT_W'(FIRE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_REF_LAST  = c_CNT_W'(REFRACT - 1);

    generate
        if (LEAK_PERIOD < 1 || FIRE_CYCLES < 1 || REFRACT < 1 || THRESH < 1 ||
            THRESH >= 2 ** (ACC_W - 1) || IN_W >= ACC_W) begin : g_paramCheck
            $error("mod_lif_neuron: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        INTEGRATE = 2'd0,
        FIRE      = 2'd1,
        REFRACT_S = 2'd2
    } state_t;

    state_t               r_state,      w_stateNext;
    logic [c_CNT_W-1:0]   r_cnt,        w_cntNext;
    logic [ACC_W-1:0]     r_potential,  w_potNext;
    logic                 r_spike,      w_spikeNext;
    logic                 r_crit,       w_critNext;
    logic                 r_refractory, w_refrNext;
    logic                 w_leakTick;

    // ------------------------------------------------------------------
    // Leak timebase
    // ------------------------------------------------------------------
`ifdef LIF_LEAK_EN
    localparam int               c_LEAK_W    = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam logic [c_LEAK_W-1:0] c_LEAK_LAST = c_LEAK_W'(LEAK_PERIOD - 1);

    logic [c_LEAK_W-1:0] r_leakCnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_leakCnt <= '0;
        end else if (r_leakCnt == c_LEAK_LAST) begin
            r_leakCnt <= '0;
        end else begin
            r_leakCnt <= r_leakCnt + 1'b1;
        end
    end

    assign w_leakTick = (r_leakCnt == c_LEAK_LAST);
`else
    assign w_leakTick = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Integration datapath at ACC_W+1 bits so one weight can neither wrap
    // past the positive limit nor hide a negative result.
    // ------------------------------------------------------------------
    logic signed [ACC_W:0] w_pExt;
    logic signed [ACC_W:0] w_wExt;
    logic signed [ACC_W:0] w_p1;
    logic signed [ACC_W:0] w_p2;
    logic [ACC_W-1:0]      w_sat;

    // Potential is never negative, so the extension bit is always zero.
    assign w_pExt = {1'b0, r_potential};
    assign w_wExt = {{(ACC_W + 1 - IN_W){nrn.inWeight[IN_W-1]}}, nrn.inWeight};
    assign w_p1   = w_leakTick ? (w_pExt - (w_pExt >>> LEAK_SHIFT)) : w_pExt;
    assign w_p2   = nrn.inValid ? (w_p1 + w_wExt) : w_p1;

    // Bit ACC_W flags a negative sum; bit ACC_W-1 of a non-negative sum
    // flags overflow above the largest positive potential.
    assign w_sat = w_p2[ACC_W]   ? '0      :
                   w_p2[ACC_W-1] ? c_P_MAX : w_p2[ACC_W-1:0];

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state      <= INTEGRATE;
            r_cnt        <= '0;
            r_potential  <= '0;
            r_spike      <= 1'b0;
            r_crit       <= 1'b0;
            r_refractory <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_cnt        <= w_cntNext;
            r_potential  <= w_potNext;
            r_spike      <= w_spikeNext;
            r_crit       <= w_critNext;
            r_refractory <= w_refrNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_potNext   = r_potential;
        w_spikeNext = 1'b0;
        w_critNext  = 1'b0;
        w_refrNext  = 1'b0;

        case (r_state)
            INTEGRATE: begin
                w_potNext = w_sat;
                if (w_sat >= c_THRESH) begin
                    w_stateNext = FIRE;
                    w_cntNext   = '0;
                end
            end

            // Counts 0..FIRE_CYCLES drive the spike; critOut drops one
            // cycle early so the latch closes while its data is still 1.
            FIRE: begin
                if (r_cnt == c_FIRE_LAST) begin
                    w_potNext   = '0;
                    w_stateNext = REFRACT_S;
                    w_refrNext  = 1'b1;
                    w_cntNext   = '0;
                end else begin
                    w_spikeNext = 1'b1;
                    w_critNext  = (r_cnt < c_FIRE_CRIT);
                    w_cntNext   = r_cnt + 1'b1;
                end
            end

            REFRACT_S: begin
                w_potNext = '0;
                if (r_cnt == c_REF_LAST) begin
                    w_stateNext = INTEGRATE;
                    w_cntNext   = '0;
                end else begin
                    w_refrNext = 1'b1;
                    w_cntNext  = r_cnt + 1'b1;
                end
            end

            default: begin
                w_stateNext = INTEGRATE;
                w_cntNext   = '0;
                w_potNext   = '0;
            end
        endcase
    end

    assign nrn.spikeOut   = r_spike;
    assign nrn.critOut    = r_crit;
    assign nrn.potential  = r_potential;
    assign nrn.refractory = r_refractory;

endmodule
`default_nettype wire

// File: tb/tb_mod_lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_lif_neuron
//  Purpose  : Directed self-checking bench for mod_lif_neuron. Main instance
//             uses default parameters; a second instance uses THRESH=2047
//             to exercise saturation. Build with LIF_LEAK_EN defined to run
//             the leak sequence instead of the pure-integrator sequence.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mod_lif_neuron;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    always #5 clk = ~clk;

    mod_lif_neuron_if #(.IN_W(8), .ACC_W(12)) bus ();
    mod_lif_neuron_if #(.IN_W(8), .ACC_W(12)) busSat ();

    mod_lif_neuron dut (
        .clk  (clk),
        .rstN (rstN),
        .nrn  (bus.slave)
    );

    mod_lif_neuron #(.THRESH(2047)) dutSat (
        .clk  (clk),
        .rstN (rstN),
        .nrn  (busSat.slave)
    );

    // Downstream D-latch: transparent while critOut is high.
    logic latchQ = 1'b0;
    always_latch begin
        if (bus.critOut) latchQ = bus.spikeOut;
    end

    int   nChecks  = 0;
    int   nErrors  = 0;
    logic prevCrit = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 ns later, and check latch framing.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("crit_implies_spike", int'(bus.critOut && !bus.spikeOut), 0);
        if (prevCrit && !bus.critOut) chk("crit_fall_spike", int'(bus.spikeOut), 1);
        prevCrit = bus.critOut;
    endtask

    initial begin
        bus.inValid     = 1'b0;
        bus.inWeight    = '0;
        busSat.inValid  = 1'b0;
        busSat.inWeight = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spike", int'(bus.spikeOut),   0);
        chk("rst_crit",  int'(bus.critOut),    0);
        chk("rst_pot",   int'(bus.potential),  0);
        chk("rst_refr",  int'(bus.refractory), 0);
        chk("rst_sat_pot", int'(busSat.potential), 0);

`ifdef LIF_LEAK_EN
        // ---------------- leak ----------------
        // Leak counter is 0 from release; the 8th edge applies the first leak.
        @(negedge clk) rstN = 1'b1;
        bus.inValid  = 1'b1;
        bus.inWeight = 8'sd127;
        for (int i = 0; i < 6; i++) tick();
        bus.inWeight = 8'sd38;
        tick();
        chk("leak_load", int'(bus.potential), 800);
        bus.inValid = 1'b0;
        tick();
        chk("leak_1", int'(bus.potential), 750);
        for (int i = 0; i < 7; i++) tick();
        chk("leak_hold", int'(bus.potential), 750);
        tick();
        chk("leak_2", int'(bus.potential), 704);
`else
        // ---------------- negative floor ----------------
        @(negedge clk) rstN = 1'b1;
        bus.inValid  = 1'b1;
        bus.inWeight = 8'sd50;
        tick();
        chk("floor_load", int'(bus.potential), 50);
        bus.inWeight = -8'sd128;
        tick();
        chk("floor_zero", int'(bus.potential), 0);

        // ---------------- pure integration and spike framing ----------------
        bus.inWeight = 8'sd100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("int_pot", int'(bus.potential), 100 * (i + 1));
            chk("int_nospike", int'(bus.spikeOut), 0);
        end
        // Inputs stay applied through FIRE to show they are ignored.
        tick();
        chk("fire1_spike", int'(bus.spikeOut), 1);
        chk("fire1_crit",  int'(bus.critOut),  1);
        chk("fire1_pot",   int'(bus.potential), 1000);
        tick();
        chk("fire2_spike", int'(bus.spikeOut), 1);
        chk("fire2_crit",  int'(bus.critOut),  1);
        tick();
        chk("fire3_spike", int'(bus.spikeOut), 1);
        chk("fire3_crit",  int'(bus.critOut),  0);
        chk("fire3_pot",   int'(bus.potential), 1000);
        tick();
        chk("post_spike", int'(bus.spikeOut),   0);
        chk("post_crit",  int'(bus.critOut),    0);
        chk("post_pot",   int'(bus.potential),  0);
        chk("post_refr",  int'(bus.refractory), 1);
        chk("latch_q",    int'(latchQ),         1);

        // ---------------- refractory discard ----------------
        bus.inWeight = 8'sd127;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("refr_flag",    int'(bus.refractory), (k < 15) ? 1 : 0);
            chk("refr_pot",     int'(bus.potential),  0);
            chk("refr_nospike", int'(bus.spikeOut),   0);
        end
        tick();
        chk("refr_first_in", int'(bus.potential), 127);
        bus.inValid = 1'b0;

        // ---------------- saturation (THRESH=2047 instance) ----------------
        busSat.inValid  = 1'b1;
        busSat.inWeight = 8'sd127;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk("sat_pot", int'(busSat.potential), (127 * (i + 1) > 2047) ? 2047 : 127 * (i + 1));
            chk("sat_nospike", int'(busSat.spikeOut), 0);
        end
        busSat.inValid = 1'b0;
        tick();
        chk("sat_fire_spike", int'(busSat.spikeOut), 1);
        chk("sat_fire_crit",  int'(busSat.critOut),  1);
        chk("sat_fire_pot",   int'(busSat.potential), 2047);

        // ---------------- reset during FIRE cycle 1 ----------------
        bus.inValid  = 1'b1;
        bus.inWeight = 8'sd127;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("pre_rst_pot", int'(bus.potential), 127 * (i + 2));
        end
        bus.inValid = 1'b0;
        tick();
        chk("pre_rst_spike", int'(bus.spikeOut), 1);
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_spike", int'(bus.spikeOut),   0);
        chk("arst_crit",  int'(bus.critOut),    0);
        chk("arst_pot",   int'(bus.potential),  0);
        chk("arst_refr",  int'(bus.refractory), 0);
        @(negedge clk);
        rstN         = 1'b1;
        prevCrit     = 1'b0;
        bus.inValid  = 1'b1;
        bus.inWeight = 8'sd100;
        tick();
        chk("after_rst_pot",   int'(bus.potential),  100);
        chk("after_rst_spike", int'(bus.spikeOut),   0);
        chk("after_rst_refr",  int'(bus.refractory), 0);
        bus.inValid = 1'b0;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
